// File: rtl/fifo_line_reader_pkg.sv
// Shared types and defaults for the cache-line FIFO read-side serialiser.
package fifo_line_reader_pkg;

    // Line and word geometry defaults; the line width must match the FIFO data width.
    localparam int unsigned DefCashStrWidth = 64;
    localparam int unsigned DefWordWidth    = 16;
    localparam int unsigned DefIdxWidth     = 2;
    localparam int unsigned DefCntWidth     = 16;

    // Encodings are fixed so the state can be probed against the legacy 2-bit values.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StSend = 2'd2
    } state_e;

    // Maps an emission-order word index onto its physical slot in the line.
    function automatic int unsigned word_slot(input int unsigned idx, input int unsigned words,
                                              input bit msw_first);
        return msw_first ? (words - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/fifo_line_reader_if.sv
// Word stream from the line reader toward the CPU-side datapath.
interface fifo_line_reader_if #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned IDX_WIDTH  = 2
);
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [IDX_WIDTH-1:0]  out_word_idx;

    modport master (
        output out_data, out_valid, out_last, out_word_idx,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_last, out_word_idx,
        output out_ready
    );
endinterface

// File: rtl/fifo_line_reader.sv
// Pops cache lines from the async FIFO and serialises them into words on a valid/ready stream.
module fifo_line_reader
    import fifo_line_reader_pkg::*;
#(
    parameter int unsigned CASH_STR_WIDTH = DefCashStrWidth,
    parameter int unsigned WORD_WIDTH     = DefWordWidth,
    parameter int unsigned IDX_WIDTH      = DefIdxWidth,
    parameter bit          MSW_FIRST      = 1'b0,
    parameter int unsigned CNT_WIDTH      = DefCntWidth
) (
    input  logic                      rd_clk,
    input  logic                      not_reset,
    input  logic                      enable,
    input  logic [CASH_STR_WIDTH-1:0] fifo_dout,
    input  logic                      fifo_empty,
    output logic                      fifo_read,
    fifo_line_reader_if.master        word_if,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      lines_read
);

    localparam int unsigned WORDS = CASH_STR_WIDTH / WORD_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WORDS - 1);

    state_e                    state_q, state_d;
    logic [CASH_STR_WIDTH-1:0] line_buf_q;
    logic [IDX_WIDTH-1:0]      word_idx_q;
    logic [CNT_WIDTH-1:0]      lines_read_q;

    logic sending;
    logic last_word;
    logic handshake;
    logic last_hs;
    int unsigned slot;

    assign sending   = (state_q == StSend);
    assign last_word = (word_idx_q == LAST_IDX);
    assign handshake = sending & word_if.out_ready;
    assign last_hs   = handshake & last_word;

    // State register; reset drops any line in flight.
    always_ff @(posedge rd_clk or negedge not_reset) begin
        if (!not_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: LOAD is a single capture cycle, a pop on the last handshake chains lines.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fifo_read) state_d = StLoad;
            StLoad:  state_d = StSend;
            StSend:  if (last_hs) state_d = fifo_read ? StLoad : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: capture the line, walk the word index, count completed lines.
    always_ff @(posedge rd_clk or negedge not_reset) begin
        if (!not_reset) begin
            line_buf_q   <= '0;
            word_idx_q   <= '0;
            lines_read_q <= '0;
        end else begin
            if (state_q == StLoad) begin
                line_buf_q <= fifo_dout;
                word_idx_q <= '0;
            end else if (handshake && !last_word) begin
                word_idx_q <= word_idx_q + 1'b1;
            end
            if (last_hs) begin
                lines_read_q <= lines_read_q + 1'b1;
            end
        end
    end

    // Outputs: pop request, word mux and status.
    always_comb begin
        slot = word_slot(32'(word_idx_q), WORDS, MSW_FIRST);
        // Reset gates the pop so nothing leaves the FIFO while the block is held in reset.
        fifo_read = not_reset & enable & ~fifo_empty & ((state_q == StIdle) | last_hs);
        word_if.out_valid    = sending;
        word_if.out_data     = WORD_WIDTH'(line_buf_q >> (slot * WORD_WIDTH));
        word_if.out_last     = sending & last_word;
        word_if.out_word_idx = word_idx_q;
        busy                 = (state_q != StIdle);
        lines_read           = lines_read_q;
    end

endmodule

// File: tb/tb_fifo_line_reader.sv
// Scoreboard bench: two readers (LSW-first 16-bit count, MSW-first 3-bit count) fed by FIFO models.
module tb_fifo_line_reader;

    logic rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic        not_reset;
    logic        enable_a, enable_b;
    logic [63:0] fifo_a_dout, fifo_b_dout;
    logic        fifo_a_empty, fifo_b_empty, fifo_a_read, fifo_b_read;
    logic        busy_a, busy_b;
    logic [15:0] lines_a;
    logic [2:0]  lines_b;

    fifo_line_reader_if #(.WORD_WIDTH(16), .IDX_WIDTH(2)) if_a ();
    fifo_line_reader_if #(.WORD_WIDTH(16), .IDX_WIDTH(2)) if_b ();

    fifo_line_reader #(.MSW_FIRST(1'b0), .CNT_WIDTH(16)) dut_a (
        .rd_clk     (rd_clk),
        .not_reset  (not_reset),
        .enable     (enable_a),
        .fifo_dout  (fifo_a_dout),
        .fifo_empty (fifo_a_empty),
        .fifo_read  (fifo_a_read),
        .word_if    (if_a),
        .busy       (busy_a),
        .lines_read (lines_a)
    );

    fifo_line_reader #(.MSW_FIRST(1'b1), .CNT_WIDTH(3)) dut_b (
        .rd_clk     (rd_clk),
        .not_reset  (not_reset),
        .enable     (enable_b),
        .fifo_dout  (fifo_b_dout),
        .fifo_empty (fifo_b_empty),
        .fifo_read  (fifo_b_read),
        .word_if    (if_b),
        .busy       (busy_b),
        .lines_read (lines_b)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [1:0]  idx;
    } exp_t;

    exp_t        exp_a[$], exp_b[$];
    logic [63:0] mem_a[$], mem_b[$];
    int          pop_cyc_a[$];
    int total = 0, bad = 0, cyc = 0, hs_a = 0;
    int last_pop_a = 0, first_valid_a = 0, last_done_a = 0;
    bit pop_a = 0, pop_b = 0, prev_valid_a = 0, held_pend = 0;
    exp_t held, cur_a, cur_b, got_a, got_b;

    assign fifo_a_empty = (mem_a.size() == 0);
    assign fifo_b_empty = (mem_b.size() == 0);

    always @(posedge rd_clk) cyc <= cyc + 1;

    // FIFO models: pop request sampled mid-cycle, registered read data updates on the edge.
    always @(negedge rd_clk) begin
        pop_a = fifo_a_read;
        pop_b = fifo_b_read;
    end
    always @(posedge rd_clk) begin
        if (pop_a && mem_a.size() != 0) begin
            fifo_a_dout <= mem_a[0];
            mem_a.delete(0);
        end
        if (pop_b && mem_b.size() != 0) begin
            fifo_b_dout <= mem_b[0];
            mem_b.delete(0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic issue_a(input logic [63:0] line);
        exp_t e;
        mem_a.push_back(line);
        for (int i = 0; i < 4; i++) begin
            e.data = line[i*16 +: 16];
            e.last = (i == 3);
            e.idx  = 2'(i);
            exp_a.push_back(e);
        end
    endtask

    task automatic issue_b(input logic [63:0] line);
        exp_t e;
        mem_b.push_back(line);
        for (int i = 0; i < 4; i++) begin
            e.data = line[(3-i)*16 +: 16];
            e.last = (i == 3);
            e.idx  = 2'(i);
            exp_b.push_back(e);
        end
    endtask

    task automatic wait_idle_a(input int budget, input string name);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            if (exp_a.size() == 0 && !busy_a) begin
                done = 1;
                break;
            end
            step();
        end
        check(name, done, 1);
    endtask

    task automatic wait_idle_b(input int budget, input string name);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            if (exp_b.size() == 0 && !busy_b) begin
                done = 1;
                break;
            end
            step();
        end
        check(name, done, 1);
    endtask

    // Monitor A: scoreboard pop on handshake, hold-stability while stalled, pop legality.
    always @(negedge rd_clk) begin
        if (fifo_a_read) begin
            check("a pop while empty", fifo_a_empty, 0);
            last_pop_a = cyc;
            pop_cyc_a.push_back(cyc);
        end
        if (if_a.out_valid && !prev_valid_a) first_valid_a = cyc;
        prev_valid_a = if_a.out_valid;
        if (if_a.out_valid) begin
            cur_a.data = if_a.out_data;
            cur_a.last = if_a.out_last;
            cur_a.idx  = if_a.out_word_idx;
            if (held_pend) check("a hold data/last/idx", cur_a, held);
            if (if_a.out_ready) begin
                hs_a++;
                check("a word expected", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) begin
                    got_a = exp_a.pop_front();
                    check("a word data/last/idx", cur_a, got_a);
                end
                if (cur_a.last) last_done_a = cyc;
                held_pend = 0;
            end else begin
                held_pend = 1;
                held = cur_a;
            end
        end else begin
            held_pend = 0;
        end
    end

    // Monitor B: MSW-first word order.
    always @(negedge rd_clk) begin
        if (fifo_b_read) check("b pop while empty", fifo_b_empty, 0);
        if (if_b.out_valid && if_b.out_ready) begin
            cur_b.data = if_b.out_data;
            cur_b.last = if_b.out_last;
            cur_b.idx  = if_b.out_word_idx;
            check("b word expected", exp_b.size() != 0, 1);
            if (exp_b.size() != 0) begin
                got_b = exp_b.pop_front();
                check("b word data/last/idx", cur_b, got_b);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        int hs0;
        not_reset = 1'b1;
        enable_a = 1'b0;
        enable_b = 1'b1;
        if_a.out_ready = 1'b0;
        if_b.out_ready = 1'b1;
        #1 not_reset = 1'b0;
        #1;
        check("reset out_valid", if_a.out_valid, 0);
        check("reset fifo_read", fifo_a_read, 0);
        check("reset lines_read", lines_a, 0);
        check("reset busy", busy_a, 0);
        check("reset out_data", if_a.out_data, 0);
        check("reset out_last", if_a.out_last, 0);
        check("reset out_word_idx", if_a.out_word_idx, 0);
        step();
        not_reset = 1'b1;
        step();

        // Single line, free-flowing consumer.
        enable_a = 1'b1;
        if_a.out_ready = 1'b1;
        issue_a(64'h4444_3333_2222_1111);
        wait_idle_a(40, "t2 idle timeout");
        check("t2 latency", first_valid_a - last_pop_a, 2);
        check("t2 lines_read", lines_a, 1);

        // Stalling consumer.
        if_a.out_ready = 1'b0;
        hs0 = hs_a;
        issue_a(64'h4444_3333_2222_1111);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (if_a.out_valid) begin
                found = 1;
                break;
            end
            step();
        end
        check("t3 valid timeout", found, 1);
        for (int i = 0; i < 7; i++) begin
            if_a.out_ready = pat[i];
            step();
        end
        if_a.out_ready = 1'b1;
        check("t3 handshakes", hs_a - hs0, 4);
        check("t3 leftover words", exp_a.size(), 0);
        check("t3 lines_read", lines_a, 2);
        check("t3 idle", busy_a, 0);

        // Three pre-loaded lines back to back.
        enable_a = 1'b0;
        issue_a(64'h0004_0003_0002_0001);
        issue_a(64'h0014_0013_0012_0011);
        issue_a(64'h0024_0023_0022_0021);
        step();
        pop_cyc_a.delete();
        enable_a = 1'b1;
        wait_idle_a(60, "t4 idle timeout");
        check("t4 pop count", pop_cyc_a.size(), 3);
        if (pop_cyc_a.size() == 3) begin
            check("t4 second pop", pop_cyc_a[1] - pop_cyc_a[0], 5);
            check("t4 third pop", pop_cyc_a[2] - pop_cyc_a[0], 10);
            check("t4 last word", last_done_a - pop_cyc_a[0], 15);
        end
        check("t4 lines_read", lines_a, 5);

        // Empty FIFO, then disabled, then enable dropped mid-line.
        for (int i = 0; i < 20; i++) begin
            step();
            check("t5 empty fifo_read", fifo_a_read, 0);
            check("t5 empty busy", busy_a, 0);
        end
        enable_a = 1'b0;
        issue_a(64'hAAA4_AAA3_AAA2_AAA1);
        issue_a(64'hBBB4_BBB3_BBB2_BBB1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("t5 disabled fifo_read", fifo_a_read, 0);
            check("t5 disabled busy", busy_a, 0);
        end
        enable_a = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (if_a.out_valid && if_a.out_word_idx == 2'd1) begin
                found = 1;
                break;
            end
            step();
        end
        check("t5 word1 timeout", found, 1);
        enable_a = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy_a) begin
                found = 1;
                break;
            end
            step();
        end
        check("t5 finish timeout", found, 1);
        check("t5 remaining words", exp_a.size(), 4);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t5 after drop fifo_read", fifo_a_read, 0);
            check("t5 after drop busy", busy_a, 0);
        end
        check("t5 fifo depth", mem_a.size(), 1);
        check("t5 lines_read", lines_a, 6);
        enable_a = 1'b1;
        wait_idle_a(40, "t5 drain timeout");
        check("t5 lines_read drained", lines_a, 7);

        // Reset while word 2 is stalled.
        issue_a(64'h4444_3333_2222_1111);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (if_a.out_valid && if_a.out_word_idx == 2'd2) begin
                found = 1;
                break;
            end
            step();
        end
        check("t1 word2 timeout", found, 1);
        if_a.out_ready = 1'b0;
        mem_a.push_back(64'hDEAD_BEEF_DEAD_BEEF);
        #2 not_reset = 1'b0;
        #1;
        check("t1 out_valid", if_a.out_valid, 0);
        check("t1 fifo_read", fifo_a_read, 0);
        check("t1 lines_read", lines_a, 0);
        check("t1 busy", busy_a, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1 held fifo_read", fifo_a_read, 0);
        end
        exp_a.delete();
        mem_a.delete();
        enable_a = 1'b0;
        if_a.out_ready = 1'b1;
        not_reset = 1'b1;
        step();
        check("t1 idle busy", busy_a, 0);
        check("t1 idle out_valid", if_a.out_valid, 0);

        // MSW-first order and counter wrap on the 3-bit reader.
        for (int k = 0; k < 7; k++) begin
            issue_b({16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)});
        end
        wait_idle_b(100, "t6 idle timeout");
        check("t6 lines_read 7", lines_b, 7);
        issue_b(64'h4444_3333_2222_1111);
        wait_idle_b(40, "t6 wrap timeout");
        check("t6 lines_read wrap", lines_b, 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
